// File: rtl/gate.sv
// ---------------------------------------------------------------------------
// gate: configurable bitwise two-input logic gate.
//   Y      - combinational result of A and B under the operation register
//   Y_q    - Y captured at every rising clk edge
//   op_cur - operation register, loaded from op when op_load is high
//
// Optional feature (macro GATE_STATS_EN): adds stats_clr input and hi_cnt
// output. hi_cnt is a saturating count of clock edges at which Y_q was
// nonzero. Without the macro the counter and both ports do not exist.
//
// Reset is asynchronous and active-low. It forces op_cur to DEFAULT_OP and
// clears Y_q (and hi_cnt) at once. On release, the first rising clk edge is
// the first one that updates state.
// ---------------------------------------------------------------------------
module gate #(
    parameter int          WIDTH      = 1,
    parameter logic [2:0]  DEFAULT_OP = 3'd0,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    input  logic             op_load,
`ifdef GATE_STATS_EN
    input  logic             stats_clr,
    output logic [CNT_W-1:0] hi_cnt,
`endif
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Y_q,
    output logic [2:0]       op_cur
);

    // Operation codes
    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd1;
    localparam logic [2:0] OP_XOR   = 3'd2;
    localparam logic [2:0] OP_NAND  = 3'd3;
    localparam logic [2:0] OP_NOR   = 3'd4;
    localparam logic [2:0] OP_XNOR  = 3'd5;
    localparam logic [2:0] OP_ANDNB = 3'd6;
    localparam logic [2:0] OP_NOTA  = 3'd7;

    // Bitwise evaluation of one operation over the full operand width.
    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       sel,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (sel)
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_NAND:  r = ~(a & b);
            OP_NOR:   r = ~(a | b);
            OP_XNOR:  r = ~(a ^ b);
            OP_ANDNB: r = a & ~b;
            OP_NOTA:  r = ~a;
            default:  r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    // Combinational result; follows A, B and op_cur with no clock or reset gating.
    always_comb begin
        Y = apply_op(op_cur, A, B);
    end

    // Operation register: loads op only on an edge with op_load high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cur <= DEFAULT_OP;
        end else if (op_load) begin
            op_cur <= op;
        end else begin
            op_cur <= op_cur;
        end
    end

    // Registered copy of Y, one clock behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y_q <= {WIDTH{1'b0}};
        end else begin
            Y_q <= Y;
        end
    end

`ifdef GATE_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Saturating count of edges with nonzero Y_q; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_cnt <= {CNT_W{1'b0}};
        end else if (stats_clr) begin
            hi_cnt <= {CNT_W{1'b0}};
        end else if ((|Y_q) && (hi_cnt != CNT_MAX)) begin
            hi_cnt <= hi_cnt + CNT_ONE;
        end else begin
            hi_cnt <= hi_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_gate.sv
// ---------------------------------------------------------------------------
// tb_gate: scoreboard bench for gate (WIDTH=4, CNT_W=2, DEFAULT_OP=AND).
// The reference model is a per-bit truth-table lookup. The driver pushes the
// expected Y for each cycle and the expected Y_q/op_cur/hi_cnt after the
// next edge. Two monitors pop and compare these values independently.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gate;

    localparam int W  = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          clk_en = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic [2:0]    op = 3'd0;
    logic          op_load = 1'b0;
    logic          stats_clr = 1'b0;
    logic [W-1:0]  Y;
    logic [W-1:0]  Y_q;
    logic [2:0]    op_cur;
    logic [CW-1:0] hi_cnt_s;

    gate #(.WIDTH(W), .DEFAULT_OP(3'd0), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .op(op), .op_load(op_load),
`ifdef GATE_STATS_EN
        .stats_clr(stats_clr), .hi_cnt(hi_cnt_s),
`endif
        .Y(Y), .Y_q(Y_q), .op_cur(op_cur)
    );

`ifndef GATE_STATS_EN
    assign hi_cnt_s = '0;
`endif

    // Clock runs only once enabled, so the first phase has no edges.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Per-op truth table, bit index {a,b}: 00->bit0 ... 11->bit3.
    logic [3:0] tbl [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111,
                            4'b0001, 4'b1001, 4'b0100, 4'b0011};

    function automatic logic [W-1:0] model_y(input logic [2:0] o,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W-1:0] r;
        logic [3:0]   row;
        row = tbl[o];
        for (int i = 0; i < W; i++) begin
            r[i] = row[{a[i], b[i]}];
        end
        return r;
    endfunction

    typedef struct {
        logic [W-1:0]  yq;
        logic [2:0]    op;
        logic [CW-1:0] cnt;
    } exp_t;

    logic [W-1:0] q_y [$];
    exp_t         q_q [$];

    int tests = 0;
    int fails = 0;

    logic [2:0]    m_op  = 3'd0;
    logic [W-1:0]  m_yq  = '0;
    logic [CW-1:0] m_cnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus plus the matching expectations.
    task automatic drive_cycle(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2:0] o, input logic ld, input logic clr);
        exp_t e;
        logic [W-1:0] y;
        @(posedge clk);
        #2;
        A = a; B = b; op = o; op_load = ld; stats_clr = clr;
        y = model_y(m_op, a, b);
        q_y.push_back(y);
        e.yq  = y;
        e.op  = ld ? o : m_op;
        if (clr)                   e.cnt = '0;
        else if (m_yq == '0)       e.cnt = m_cnt;
        else if (m_cnt == 2'd3)    e.cnt = m_cnt;
        else                       e.cnt = m_cnt + 2'd1;
        q_q.push_back(e);
        m_op = e.op; m_yq = y; m_cnt = e.cnt;
    endtask

    // Monitor for the combinational output, mid-cycle.
    initial begin
        logic [W-1:0] ey;
        forever begin
            @(negedge clk);
            #1;
            if (q_y.size() > 0) begin
                ey = q_y.pop_front();
                check("Y", 32'(Y), 32'(ey));
            end
        end
    end

    // Monitor for registered state, just after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_q.size() > 0) begin
                e = q_q.pop_front();
                check("Y_q", 32'(Y_q), 32'(e.yq));
                check("op_cur", 32'(op_cur), 32'(e.op));
`ifdef GATE_STATS_EN
                check("hi_cnt", 32'(hi_cnt_s), 32'(e.cnt));
`endif
            end
        end
    end

    // Watchdog against a hung run.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] ab;
        // Reset phase with no clock edges: truth table of AND.
        #1;
        check("rst_op_cur", 32'(op_cur), 32'd0);
        check("rst_Y_q", 32'(Y_q), 32'd0);
        check("rst_hi_cnt", 32'(hi_cnt_s), 32'd0);
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            A = {W{ab[1]}};
            B = {W{ab[0]}};
            #50;
            check("rst_tt_Y", 32'(Y), (i == 3) ? 32'hF : 32'h0);
        end
        A = 4'b1010; B = 4'b0110;
        #1;
        check("rst_and_Y", 32'(Y), 32'h2);

        // Clock on, reset still held: op_load must be ignored.
        clk_en = 1'b1;
        op = 3'd3; op_load = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ignore_load", 32'(op_cur), 32'd0);
        check("rst_hold_Y_q", 32'(Y_q), 32'd0);
        op_load = 1'b0; A = '0; B = '0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Load XOR, then 11 -> 0 and 10 -> 1.
        drive_cycle(4'hF, 4'hF, 3'd2, 1'b1, 1'b0);
        drive_cycle(4'hF, 4'hF, 3'd0, 1'b0, 1'b0);
        drive_cycle(4'hF, 4'h0, 3'd0, 1'b0, 1'b0);

        // Sweep every op over all four uniform input pairs.
        for (int o = 0; o < 8; o++) begin
            drive_cycle(W'($urandom), W'($urandom), 3'(o), 1'b1, 1'b0);
            for (int i = 0; i < 4; i++) begin
                ab = 2'(i);
                drive_cycle({W{ab[1]}}, {W{ab[0]}}, 3'd0, 1'b0, 1'b0);
            end
        end

        // Wide OR: 1010 | 0101 = 1111.
        drive_cycle(4'b1010, 4'b0101, 3'd1, 1'b1, 1'b0);
        drive_cycle(4'b1010, 4'b0101, 3'd0, 1'b0, 1'b0);

        // Counter: clear, then hold Y_q high long enough to saturate.
        drive_cycle(4'h0, 4'h0, 3'd0, 1'b1, 1'b1);
        drive_cycle(4'h0, 4'h0, 3'd1, 1'b1, 1'b1);
        repeat (6) drive_cycle(4'h1, 4'h0, 3'd1, 1'b0, 1'b0);
        drive_cycle(4'h1, 4'h0, 3'd1, 1'b0, 1'b1);
        drive_cycle(4'h1, 4'h0, 3'd1, 1'b0, 1'b0);

        // Randomized traffic.
        for (int k = 0; k < 300; k++) begin
            drive_cycle(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)),
                        ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
        end

        // Mid-cycle reset while op_cur = XNOR, with a load pending.
        drive_cycle(4'b1100, 4'b1010, 3'd5, 1'b1, 1'b0);
        drive_cycle(4'b1100, 4'b1010, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        op = 3'd6; op_load = 1'b1; stats_clr = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_op_cur", 32'(op_cur), 32'd0);
        check("mid_rst_Y_q", 32'(Y_q), 32'd0);
        check("mid_rst_hi_cnt", 32'(hi_cnt_s), 32'd0);
        check("mid_rst_Y_and", 32'(Y), 32'(4'b1000));
        @(posedge clk);
        #1;
        check("mid_rst_no_load", 32'(op_cur), 32'd0);
        op_load = 1'b0; A = '0; B = '0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        m_op = 3'd0; m_yq = '0; m_cnt = '0;

        // After release the first edge updates state.
        drive_cycle(4'b0110, 4'b0011, 3'd4, 1'b1, 1'b0);
        for (int k = 0; k < 40; k++) begin
            drive_cycle(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)),
                        ($urandom_range(0, 2) == 0), 1'b0);
        end

        repeat (3) @(posedge clk);
        #3;
        check("queues_drained", 32'(q_y.size() + q_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gate.md
GATE -- requirements
Module: gate

Interface
REQ-001 Parameter WIDTH, default 1: bit width of A, B, Y, Y_q.
REQ-002 Parameter DEFAULT_OP, default 3'd0 (AND): operation selected after reset.
REQ-003 Parameter CNT_W, default 16: width of the statistics counter.
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 Port A  input  WIDTH: first operand.
REQ-007 Port B  input  WIDTH: second operand.
REQ-008 Port op  input  3: operation code to load.
REQ-009 Port op_load  input  1: when high at a clk edge, op is captured into the operation register.
REQ-010 Port Y  output  WIDTH: combinational result of A, B under the current operation register.
REQ-011 Port Y_q  output  WIDTH: Y registered one clk cycle later.
REQ-012 Port op_cur  output  3: current operation register value.
REQ-013 Ports stats_clr (input, 1) and hi_cnt (output, CNT_W) exist only when GATE_STATS_EN is defined.

Function
REQ-014 Operation encoding, bitwise per bit: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 A AND NOT B, 7 NOT A (B ignored).
REQ-015 Y shall follow A, B and op_cur with zero clock latency, with no clock or reset gating.
REQ-016 With op_cur=0, the 1-bit truth table for (A,B) = 00,01,10,11 shall give Y = 0,0,0,1.
REQ-017 The operation register shall update only on a rising clk edge with op_load=1; op_load=0 holds it.
REQ-018 A new op loaded at edge N shall affect Y immediately after edge N and Y_q at edge N+1.
REQ-019 At each rising clk edge, Y_q shall capture the current value of Y.
REQ-020 Input changes between clock edges shall appear on Y only, never on Y_q, until the next edge.

Reset
REQ-021 rst_n=0 shall immediately, without waiting for a clock edge, set op_cur=DEFAULT_OP, Y_q=0 and hi_cnt=0.
REQ-022 While rst_n=0, op_load and stats_clr shall be ignored, and Y shall still reflect A, B under DEFAULT_OP.
REQ-023 Reset deassertion shall be synchronized so that the first state update occurs on the first full clk edge after the release.
REQ-024 Reset asserted mid-operation shall discard any pending op load and the counter value.

Configuration
REQ-025 When macro GATE_STATS_EN is defined, hi_cnt shall increment by 1 at each clk edge where Y_q is nonzero (reduction OR).
REQ-026 The increment shall saturate at 2^CNT_W-1, without wrapping.
REQ-027 stats_clr=1 at an edge shall zero hi_cnt, taking priority over increment.
REQ-028 Without GATE_STATS_EN, the counter logic and its ports shall be absent, and all other behaviour shall be identical.

Verification
REQ-029 Reset, no clk edges, A,B stepped 00,01,10,11 every 50 time units -> Y = 0,0,0,1.
REQ-030 op=2 loaded with op_load=1 for one edge, A=1,B=1 -> Y=0 after the edge; Y_q=0 one edge later; A=1,B=0 -> Y=1.
REQ-031 Sweep all 8 ops x 4 input pairs at WIDTH=1 -> Y matches the REQ-014 table, and Y_q equals the prior-cycle Y.
REQ-032 rst_n pulsed low between clock edges while op_cur=5 -> op_cur=0 and Y_q=0 immediately; Y recomputes as AND.
REQ-033 GATE_STATS_EN defined, CNT_W=2, Y_q held at 1 for 5 edges -> hi_cnt = 1,2,3,3,3; stats_clr together with Y_q=1 -> hi_cnt=0.
REQ-034 WIDTH=4, op=1, A=4'b1010, B=4'b0101 -> Y=4'b1111.
